// File: rtl/traceback_walker_if.sv
// traceback_walker_if: start/readback/op-stream signals between the traceback walker and its environment
interface traceback_walker_if #(
   parameter int ROW_W = 10,
   parameter int COL_W = 10
);
   logic             start;
   logic [ROW_W-1:0] end_row;
   logic [COL_W-1:0] end_col;
   logic             busy;
   logic             rd_en;
   logic [ROW_W-1:0] rd_row;
   logic [COL_W-1:0] rd_col;
   logic [3:0]       rd_data;
   logic             op_valid;
   logic             op_ready;
   logic [1:0]       op;
   logic             op_last;
   logic             done;
   modport master (
      input  start, end_row, end_col, rd_data, op_ready,
      output busy, rd_en, rd_row, rd_col, op_valid, op, op_last, done
   );
   modport slave (
      output start, end_row, end_col, rd_data, op_ready,
      input  busy, rd_en, rd_row, rd_col, op_valid, op, op_last, done
   );
endinterface

// File: rtl/traceback_walker.sv
// traceback_walker: walks the direction store from an end cell back to (0,0), emitting one op per step
module traceback_walker #(
   parameter int ROW_W = 10,
   parameter int COL_W = 10
) (
   input logic clk,
   input logic rst,
   traceback_walker_if.master bus
);
   typedef enum logic [2:0] {IDLE, READ, DECODE, EMIT, DONE} state_t;
   typedef enum logic [1:0] {M_V, M_I, M_D} mtx_t;
   localparam logic [1:0] OP_DIAG = 2'd0;
   localparam logic [1:0] OP_INS  = 2'd1;
   localparam logic [1:0] OP_DEL  = 2'd2;

   state_t           state;
   mtx_t             mtx, nmtx, smtx;
   logic [ROW_W-1:0] row, nrow, srow;
   logic [COL_W-1:0] col, ncol, scol;
   logic [1:0]       sop;
   logic             on_edge, at_origin;

   assign bus.rd_en  = state == READ && !on_edge;
   assign bus.rd_row = row;
   assign bus.rd_col = col;

   // Step decode: edges force gaps and keep the matrix; interior cells follow the 3-state tracker
   always_comb begin
      at_origin = row == '0 && col == '0;
      on_edge   = row == '0 || col == '0;
      sop  = on_edge ? (row == '0 ? OP_INS : OP_DEL) :
             mtx == M_I ? OP_INS : mtx == M_D ? OP_DEL :
             bus.rd_data[3:2] == 2'd3 ? OP_INS : bus.rd_data[3:2] == 2'd2 ? OP_DEL : OP_DIAG;
      srow = sop == OP_INS ? row : row - ROW_W'(1);
      scol = sop == OP_DEL ? col : col - COL_W'(1);
      smtx = on_edge ? mtx : sop == OP_DIAG ? M_V :
             sop == OP_INS ? (bus.rd_data[1] ? M_V : M_I) : (bus.rd_data[0] ? M_V : M_D);
   end

   // Walk FSM; the pending step is held in nrow/ncol/nmtx and committed only on the op handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         mtx          <= M_V;
         nmtx         <= M_V;
         row          <= '0;
         col          <= '0;
         nrow         <= '0;
         ncol         <= '0;
         bus.busy     <= 1'b0;
         bus.op_valid <= 1'b0;
         bus.op       <= 2'd0;
         bus.op_last  <= 1'b0;
         bus.done     <= 1'b0;
      end else begin
         if ((state == READ && on_edge && !at_origin) || state == DECODE) begin
            bus.op       <= sop;
            bus.op_last  <= srow == '0 && scol == '0;
            bus.op_valid <= 1'b1;
            nrow         <= srow;
            ncol         <= scol;
            nmtx         <= smtx;
         end
         case (state)
            IDLE: if (bus.start) begin
               row      <= bus.end_row;
               col      <= bus.end_col;
               mtx      <= M_V;
               bus.busy <= 1'b1;
               state    <= READ;
            end
            READ: begin
               state    <= at_origin ? DONE : on_edge ? EMIT : DECODE;
               bus.done <= at_origin;
            end
            DECODE: state <= EMIT;
            EMIT: if (bus.op_ready) begin
               bus.op_valid <= 1'b0;
               row          <= nrow;
               col          <= ncol;
               mtx          <= nmtx;
               state        <= bus.op_last ? DONE : READ;
               bus.done     <= bus.op_last;
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_traceback_walker.sv
// tb_traceback_walker: directed traceback walks against a hand-written direction store
module tb_traceback_walker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_done = 0;
   int   cyc;
   logic [3:0] mem [0:7][0:7];
   int   oq[$];
   int   lq[$];
   int   rrq[$];
   int   rcq[$];
   logic [1:0] hold_op;
   logic hold_last;
   int   n_rd;

   always #5 clk = ~clk;

   traceback_walker_if bus ();
   traceback_walker dut (.clk(clk), .rst(rst), .bus(bus.master));

   // Direction store: registered read, one cycle after the strobe
   always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_row[2:0]][bus.rd_col[2:0]];

   // Record reads, accepted ops and done pulses
   always @(posedge clk) begin
      if (!rst && bus.rd_en) begin
         rrq.push_back(int'(bus.rd_row));
         rcq.push_back(int'(bus.rd_col));
      end
      if (!rst && bus.op_valid && bus.op_ready) begin
         oq.push_back(int'(bus.op));
         lq.push_back(int'(bus.op_last));
      end
      if (!rst && bus.done) n_done++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_all();
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mem[r][c] = 4'h0;
      oq.delete(); lq.delete(); rrq.delete(); rcq.delete();
      n_done = 0;
   endtask

   task automatic walk(input int r, input int c, input bit poke);
      @(negedge clk);
      bus.start = 1'b1; bus.end_row = 10'(r); bus.end_col = 10'(c);
      @(negedge clk);
      bus.start = 1'b0; bus.end_row = '0; bus.end_col = '0;
      cyc = 1;
      while (!bus.done && cyc < 200) begin
         bus.start = poke && cyc == 3;
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
      check("walk_timeout", int'(cyc < 200), 1);
      check("busy_at_done", int'(bus.busy), 1);
      @(negedge clk);
      check("busy_after_done", int'(bus.busy), 0);
      check("done_pulses", n_done, 1);
   endtask

   task automatic chk_ops(input string tag, input int n, input int e0, input int e1, input int e2);
      int e[3];
      e = '{e0, e1, e2};
      check({tag, "_nops"}, oq.size(), n);
      for (int i = 0; i < n; i++) begin
         check({tag, "_op"}, i < oq.size() ? oq[i] : 99, e[i]);
         check({tag, "_last"}, i < lq.size() ? lq[i] : 99, int'(i == n - 1));
      end
   endtask

   task automatic chk_rd(input string tag, input int n, input int r0, input int c0,
                         input int r1, input int c1, input int r2, input int c2);
      int er[3];
      int ec[3];
      er = '{r0, r1, r2};
      ec = '{c0, c1, c2};
      check({tag, "_nrd"}, rrq.size(), n);
      for (int i = 0; i < n; i++) begin
         check({tag, "_rd_row"}, i < rrq.size() ? rrq[i] : 99, er[i]);
         check({tag, "_rd_col"}, i < rcq.size() ? rcq[i] : 99, ec[i]);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.end_row = '0; bus.end_col = '0; bus.op_ready = 1'b1; bus.rd_data = 4'h0;
      clear_all();
      repeat (3) @(negedge clk);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_valid", int'(bus.op_valid), 0);
      check("rst_rd_en", int'(bus.rd_en), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_op", int'(bus.op), 0);
      rst = 1'b0;

      // Pure diagonal, with a start pulse mid-walk that must be ignored
      clear_all();
      mem[3][3] = 4'b0100; mem[2][2] = 4'b0100; mem[1][1] = 4'b0100;
      walk(3, 3, 1'b1);
      check("diag_cycles", cyc, 10);
      chk_ops("diag", 3, 0, 0, 0);
      chk_rd("diag", 3, 3, 3, 2, 2, 1, 1);

      // Affine deletion run; (2,1) has v_dir=3 to expose a wrong matrix
      clear_all();
      mem[3][1] = 4'b1000; mem[2][1] = 4'b1101; mem[1][1] = 4'b0100;
      walk(3, 1, 1'b0);
      check("aff_cycles", cyc, 10);
      chk_ops("aff", 3, 2, 2, 0);
      chk_rd("aff", 3, 3, 1, 2, 1, 1, 1);

      // Edge gaps
      clear_all();
      walk(2, 0, 1'b0);
      check("edge_d_cycles", cyc, 5);
      chk_ops("edge_d", 2, 2, 2, 0);
      check("edge_d_nrd", rrq.size(), 0);
      clear_all();
      walk(0, 3, 1'b0);
      check("edge_i_cycles", cyc, 7);
      chk_ops("edge_i", 3, 1, 1, 1);
      check("edge_i_nrd", rrq.size(), 0);

      // Insertion run then diagonal; (1,2) has v_dir=2 to expose a wrong matrix
      clear_all();
      mem[1][3] = 4'b1100; mem[1][2] = 4'b1010; mem[1][1] = 4'b0000;
      walk(1, 3, 1'b0);
      check("ins_cycles", cyc, 10);
      chk_ops("ins", 3, 1, 1, 0);
      chk_rd("ins", 3, 1, 3, 1, 2, 1, 1);

      // Backpressure on the first diagonal op
      clear_all();
      mem[3][3] = 4'b0100; mem[2][2] = 4'b0100; mem[1][1] = 4'b0100;
      bus.op_ready = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.end_row = 10'd3; bus.end_col = 10'd3;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (!bus.op_valid && cyc < 50) begin @(negedge clk); cyc++; end
      check("bp_valid_timeout", int'(cyc < 50), 1);
      hold_op = bus.op; hold_last = bus.op_last; n_rd = rrq.size();
      check("bp_first_op", int'(hold_op), 0);
      check("bp_first_last", int'(hold_last), 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid_held", int'(bus.op_valid), 1);
         check("bp_op_stable", int'(bus.op), int'(hold_op));
         check("bp_last_stable", int'(bus.op_last), int'(hold_last));
         check("bp_no_read", int'(bus.rd_en), 0);
      end
      check("bp_nrd_held", rrq.size(), n_rd);
      bus.op_ready = 1'b1;
      cyc = 0;
      while (!bus.done && cyc < 200) begin @(negedge clk); cyc++; end
      check("bp_done_timeout", int'(cyc < 200), 1);
      @(negedge clk);
      chk_ops("bp", 3, 0, 0, 0);
      chk_rd("bp", 3, 3, 3, 2, 2, 1, 1);

      // Reset during the second EMIT
      clear_all();
      mem[3][3] = 4'b0100; mem[2][2] = 4'b0100; mem[1][1] = 4'b0100;
      bus.op_ready = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.end_row = 10'd3; bus.end_col = 10'd3;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op_ready = 1'b1;
      cyc = 0;
      while (!(bus.op_valid && oq.size() == 1) && cyc < 50) begin @(negedge clk); cyc++; end
      check("rmw_timeout", int'(cyc < 50), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rmw_busy", int'(bus.busy), 0);
      check("rmw_valid", int'(bus.op_valid), 0);
      check("rmw_rd_en", int'(bus.rd_en), 0);
      check("rmw_done", int'(bus.done), 0);
      check("rmw_op", int'(bus.op), 0);
      check("rmw_last", int'(bus.op_last), 0);
      repeat (4) @(negedge clk);
      check("rmw_no_more_ops", oq.size(), 1);
      check("rmw_no_done", n_done, 0);
      clear_all();
      walk(0, 0, 1'b0);
      check("origin_cycles", cyc, 2);
      check("origin_nops", oq.size(), 0);
      check("origin_nrd", rrq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
